miner_work_loader: RTL and testbench
====================================

// Module: miner_work_loader
// PURPOSE
//   Work-side counterpart of the miner result check: assembles a mining job from a
//   32-bit valid/ready word stream and presents midstate/data to fpgaminer_top.
//   Issues the job and watches golden_nonce/nonce_out until a hit or timeout.
//   Returns one result record per job over a valid/ready handshake.
//   Sits between the host/job source and the miner core.
// PARAMETERS
//   TIMEOUT_CYCLES  100000000  run cycles before job is abandoned; 32-bit, must be >=1
//   MID_WORDS       8          midstate words (256 bits); fixed, not overridable in use
//   DATA_WORDS      3          block-tail words (96 bits); fixed, not overridable in use
// PORTS
//   clk           in   1    single clock, all logic on posedge
//   rst_n         in   1    asynchronous, active-low reset
//   in_valid      in   1    job word valid
//   in_ready      out  1    job word accepted when in_valid & in_ready
//   in_data       in   32   job word
//   midstate      out  256  to miner; stable from work_valid until next job load
//   data          out  96   to miner; stable from work_valid until next job load
//   work_valid    out  1    one-cycle start pulse to miner
//   golden_nonce  in   32   from miner; nonzero = hit
//   nonce_out     in   32   from miner; current nonce
//   res_valid     out  1    result record valid
//   res_ready     in   1    result consumer ready
//   res_golden    out  32   golden nonce (0 on timeout)
//   res_nonce     out  32   nonce_out sampled with the hit (0 on timeout)
//   res_cycles    out  32   run cycles from issue to hit/timeout
//   timed_out     out  1    qualifies record: 1 = timeout, no hit
//   busy          out  1    high in LOAD/ISSUE/RUN/REPORT
// BEHAVIOUR
//   Reset: all outputs 0, FSM IDLE, word count 0, cycle counter 0; in_ready 0 in reset.
//   FSM: IDLE -> LOAD -> ISSUE -> RUN -> REPORT -> IDLE.
//   IDLE: in_ready=1; first accepted word -> LOAD, count=1.
//   LOAD: in_ready=1; word n (0-based) goes to midstate[32n+31:32n] for n<8,
//     data[32(n-8)+31:32(n-8)] for n=8..10. midstate/data assigned only as words
//     land; not cleared between jobs. 11th word accepted -> ISSUE.
//   ISSUE: in_ready=0; work_valid=1 exactly this cycle; cycle counter cleared -> RUN.
//     So work_valid is high the cycle after the 11th handshake.
//   RUN: in_ready=0; counter increments each cycle, saturating at 2^32-1.
//     If work_valid was high in cycle T, counter reads k in cycle T+k.
//     golden_nonce!=0 in cycle T+k: latch res_golden, res_nonce=nonce_out,
//     res_cycles=k, timed_out=0 -> REPORT.
//     Else if k==TIMEOUT_CYCLES: res_golden=0, res_nonce=0, res_cycles=k,
//     timed_out=1 -> REPORT.
//     Both in same cycle: hit wins, timed_out=0.
//   REPORT: res_valid=1 from the cycle after the latch. All res_* and timed_out
//     held stable while res_valid & !res_ready. On handshake: res_valid=0 next cycle,
//     -> IDLE. golden_nonce ignored outside RUN.
//   in_valid outside IDLE/LOAD: not accepted, no state change.
//   in_data is don't-care when in_valid=0.
//   busy = (state != IDLE).
//   Reset mid-operation (any state): immediate return to reset values.
//   Partial job discarded; no pulse or record emitted.
// TESTING
//   Load words 0x1..0xB back-to-back -> midstate[31:0]=0x1, midstate[255:224]=0x8,
//     data[95:64]=0xB; work_valid one cycle, the cycle after the 11th handshake.
//   Hit: golden_nonce=0x5302, nonce_out=0x5386 at k=100 -> res_valid next cycle,
//     res_golden=0x5302, res_nonce=0x5386, res_cycles=100, timed_out=0.
//   TIMEOUT_CYCLES=50, golden_nonce held 0 -> res_valid, timed_out=1, res_cycles=50,
//     res_golden=0, res_nonce=0.
//   Hit and timeout in same cycle (k=50, TIMEOUT_CYCLES=50) -> timed_out=0,
//     res_golden=hit value.
//   res_ready low 5 cycles, then high -> record stable all 5 cycles; IDLE and
//     in_ready=1 after the handshake.
//   rst_n low after 5 words, in_valid toggled randomly during LOAD -> no work_valid;
//     next 11 words issue the job with correct word placement.

Source files
------------

// File: rtl/miner_work_loader.sv
// rtl/miner_work_loader.sv - assembles an 11-word mining job, starts the miner, reports one hit/timeout record per job
module miner_work_loader #(
  parameter logic [31:0] TIMEOUT_CYCLES = 32'd100000000,
  parameter int          MID_WORDS      = 8,
  parameter int          DATA_WORDS     = 3
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_data,
  output logic [32*MID_WORDS-1:0]   midstate,
  output logic [32*DATA_WORDS-1:0]  data,
  output logic                      work_valid,
  input  logic [31:0]               golden_nonce,
  input  logic [31:0]               nonce_out,
  output logic                      res_valid,
  input  logic                      res_ready,
  output logic [31:0]               res_golden,
  output logic [31:0]               res_nonce,
  output logic [31:0]               res_cycles,
  output logic                      timed_out,
  output logic                      busy
);

  typedef enum logic [2:0] {S_IDLE, S_LOAD, S_ISSUE, S_RUN, S_REPORT} state_t;

  localparam logic [3:0] LAST_WORD = 4'(MID_WORDS + DATA_WORDS - 1);

  state_t                     state_q;
  logic [3:0]                 wcnt_q;
  logic [31:0]                cyc_q, cyc_d;
  logic                       in_ready_q;
  logic                       work_valid_q;
  logic [32*MID_WORDS-1:0]    mid_q;
  logic [32*DATA_WORDS-1:0]   data_q;
  logic                       res_valid_q;
  logic [31:0]                res_golden_q, res_nonce_q, res_cycles_q;
  logic                       timed_out_q;
  logic                       word_hs;
  logic                       hit;

  assign word_hs = in_valid & in_ready_q;
  assign hit     = (golden_nonce != 32'd0);
  assign cyc_d   = (cyc_q == 32'hFFFF_FFFF) ? cyc_q : cyc_q + 32'd1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= S_IDLE;
      wcnt_q       <= 4'd0;
      cyc_q        <= 32'd0;
      in_ready_q   <= 1'b0;
      work_valid_q <= 1'b0;
      mid_q        <= '0;
      data_q       <= '0;
      res_valid_q  <= 1'b0;
      res_golden_q <= 32'd0;
      res_nonce_q  <= 32'd0;
      res_cycles_q <= 32'd0;
      timed_out_q  <= 1'b0;
    end else begin
      work_valid_q <= 1'b0;

      // Job words land in place; earlier job contents persist until overwritten.
      for (int i = 0; i < MID_WORDS; i++)
        if (word_hs && wcnt_q == 4'(i)) mid_q[i*32 +: 32] <= in_data;
      for (int i = 0; i < DATA_WORDS; i++)
        if (word_hs && wcnt_q == 4'(MID_WORDS + i)) data_q[i*32 +: 32] <= in_data;

      case (state_q)
        S_IDLE, S_LOAD: begin
          in_ready_q <= 1'b1;
          if (word_hs) begin
            if (wcnt_q == LAST_WORD) begin
              wcnt_q       <= 4'd0;
              in_ready_q   <= 1'b0;
              work_valid_q <= 1'b1;
              cyc_q        <= 32'd0;
              state_q      <= S_ISSUE;
            end else begin
              wcnt_q  <= wcnt_q + 4'd1;
              state_q <= S_LOAD;
            end
          end
        end
        S_ISSUE: begin
          cyc_q   <= cyc_d;
          state_q <= S_RUN;
        end
        S_RUN: begin
          // A hit on the timeout cycle still counts as a hit.
          if (hit) begin
            res_golden_q <= golden_nonce;
            res_nonce_q  <= nonce_out;
            res_cycles_q <= cyc_q;
            timed_out_q  <= 1'b0;
            res_valid_q  <= 1'b1;
            state_q      <= S_REPORT;
          end else if (cyc_q == TIMEOUT_CYCLES) begin
            res_golden_q <= 32'd0;
            res_nonce_q  <= 32'd0;
            res_cycles_q <= cyc_q;
            timed_out_q  <= 1'b1;
            res_valid_q  <= 1'b1;
            state_q      <= S_REPORT;
          end else begin
            cyc_q <= cyc_d;
          end
        end
        S_REPORT: begin
          if (res_ready) begin
            res_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
            state_q     <= S_IDLE;
          end
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign in_ready   = in_ready_q;
  assign midstate   = mid_q;
  assign data       = data_q;
  assign work_valid = work_valid_q;
  assign res_valid  = res_valid_q;
  assign res_golden = res_golden_q;
  assign res_nonce  = res_nonce_q;
  assign res_cycles = res_cycles_q;
  assign timed_out  = timed_out_q;
  assign busy       = (state_q != S_IDLE);

endmodule

// File: tb/tb_miner_work_loader.sv
// tb/tb_miner_work_loader.sv - randomized job/run/report stimulus checked against a transaction-level model
module tb_miner_work_loader;

  localparam int TO = 100;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [31:0]  in_data;
  logic [255:0] midstate;
  logic [95:0]  data;
  logic         work_valid;
  logic [31:0]  golden_nonce, nonce_out;
  logic         res_valid, res_ready;
  logic [31:0]  res_golden, res_nonce, res_cycles;
  logic         timed_out, busy;

  always #5 clk = ~clk;

  miner_work_loader #(.TIMEOUT_CYCLES(32'(TO))) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .midstate(midstate), .data(data), .work_valid(work_valid),
    .golden_nonce(golden_nonce), .nonce_out(nonce_out),
    .res_valid(res_valid), .res_ready(res_ready), .res_golden(res_golden),
    .res_nonce(res_nonce), .res_cycles(res_cycles), .timed_out(timed_out), .busy(busy)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int n_jobs   = 0;
  int wv_seen  = 0;

  task automatic chk(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: job assembly, run time measured as cycles since issue.
  localparam int P_ACC = 0, P_ISS = 1, P_RUN = 2, P_REP = 3;
  int           m_phase, m_n, m_issue, m_cyc;
  logic [255:0] m_mid;
  logic [95:0]  m_data;
  logic         m_ir, m_wv, m_rv, m_to;
  logic [31:0]  m_rg, m_rn, m_rc;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_phase = P_ACC; m_n = 0; m_mid = '0; m_data = '0;
      m_ir = 0; m_wv = 0; m_rv = 0; m_to = 0; m_rg = 0; m_rn = 0; m_rc = 0;
    end else begin
      case (m_phase)
        P_ACC: begin
          if (in_valid && m_ir) begin
            if (m_n < 8) m_mid[32*m_n +: 32] = in_data;
            else         m_data[32*(m_n-8) +: 32] = in_data;
            m_n++;
          end
          if (m_n == 11) begin
            m_phase = P_ISS; m_n = 0; m_wv = 1; m_ir = 0; m_issue = m_cyc + 1;
          end else m_ir = 1;
        end
        P_ISS: begin m_wv = 0; m_phase = P_RUN; end
        P_RUN: begin
          int k;
          k = m_cyc - m_issue;
          if (golden_nonce != 0) begin
            m_rg = golden_nonce; m_rn = nonce_out; m_rc = 32'(k); m_to = 0; m_rv = 1; m_phase = P_REP;
          end else if (k == TO) begin
            m_rg = 0; m_rn = 0; m_rc = 32'(k); m_to = 1; m_rv = 1; m_phase = P_REP;
          end
        end
        default: if (res_ready) begin m_rv = 0; m_ir = 1; m_phase = P_ACC; end
      endcase
      m_cyc++;
    end
  end

  always @(negedge clk) begin
    if (work_valid) wv_seen++;
    chk("in_ready",   in_ready,   m_ir);
    chk("busy",       busy,       (m_phase != P_ACC) || (m_n > 0));
    chk("work_valid", work_valid, m_wv);
    chk("midstate",   midstate,   m_mid);
    chk("data",       data,       m_data);
    chk("res_valid",  res_valid,  m_rv);
    chk("res_golden", res_golden, m_rg);
    chk("res_nonce",  res_nonce,  m_rn);
    chk("res_cycles", res_cycles, m_rc);
    chk("timed_out",  timed_out,  m_to);
  end

  logic [31:0] job_w [11];

  task automatic step();
    @(posedge clk); #2;
  endtask

  task automatic send_word(input logic [31:0] w, input bit gaps);
    logic acc;
    int   g;
    if (gaps)
      while ($urandom_range(0, 2) == 0) begin
        in_valid = 1'b0; in_data = $urandom; step();
      end
    in_valid = 1'b1; in_data = w;
    g = 0;
    forever begin
      @(negedge clk); acc = in_ready;
      step();
      if (acc) break;
      g++;
      if (g > 50) begin chk("word_accept_timeout", 1'b0, 1'b1); break; end
    end
    in_valid = 1'b0;
  endtask

  task automatic load_job(input bit gaps);
    int g;
    for (int i = 0; i < 11; i++) send_word(job_w[i], gaps);
    g = 0;
    while (!work_valid && g < 20) begin step(); g++; end
    chk("work_valid_after_load", work_valid, 1'b1);
    n_jobs++;
  endtask

  task automatic run_phase(input int hitk, input logic [31:0] g, input logic [31:0] n);
    int i;
    i = 0;
    golden_nonce = 0;
    while (!res_valid && i < 400) begin
      step(); i++;
      in_valid = 1'($urandom_range(0, 1)); in_data = $urandom;
      nonce_out = $urandom;
      golden_nonce = (i == hitk) ? g : 32'h0;
      if (i == hitk) nonce_out = n;
    end
    in_valid = 1'b0;
    chk("res_valid_wait", res_valid, 1'b1);
  endtask

  task automatic drain(input int rdelay);
    logic [96:0] snap;
    snap = {res_golden, res_nonce, res_cycles, timed_out};
    for (int i = 0; i < rdelay; i++) begin
      step();
      golden_nonce = $urandom;
      chk("record_hold", {res_golden, res_nonce, res_cycles, timed_out}, snap);
    end
    res_ready = 1'b1;
    step();
    res_ready = 1'b0; golden_nonce = 0;
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in_data = 0; golden_nonce = 0; nonce_out = 0; res_ready = 0;
    repeat (3) step();
    chk("reset_in_ready", in_ready, 1'b0);
    chk("reset_busy", busy, 1'b0);
    chk("reset_res_valid", res_valid, 1'b0);
    rst_n = 1;
    step();

    for (int i = 0; i < 11; i++) job_w[i] = 32'(i + 1);
    load_job(1'b0);
    chk("pin_mid_lo", midstate[31:0], 32'h1);
    chk("pin_mid_hi", midstate[255:224], 32'h8);
    chk("pin_data_hi", data[95:64], 32'hB);

    run_phase(37, 32'h5302, 32'h5386);
    chk("pin_hit_golden", res_golden, 32'h5302);
    chk("pin_hit_nonce", res_nonce, 32'h5386);
    chk("pin_hit_cycles", res_cycles, 32'd37);
    chk("pin_hit_to", timed_out, 1'b0);
    drain(5);
    chk("pin_idle_ready", in_ready, 1'b1);
    chk("pin_idle_busy", busy, 1'b0);

    for (int i = 0; i < 11; i++) job_w[i] = $urandom;
    load_job(1'b1);
    run_phase(0, 32'h0, 32'h0);
    chk("pin_to_flag", timed_out, 1'b1);
    chk("pin_to_cycles", res_cycles, 32'(TO));
    chk("pin_to_golden", res_golden, 32'h0);
    chk("pin_to_nonce", res_nonce, 32'h0);
    drain(2);

    load_job(1'b0);
    run_phase(TO, 32'hCAFE, 32'hBEEF);
    chk("pin_tie_to", timed_out, 1'b0);
    chk("pin_tie_golden", res_golden, 32'hCAFE);
    drain(0);

    load_job(1'b1);
    run_phase(1, 32'h77, 32'h78);
    chk("pin_k1_cycles", res_cycles, 32'd1);
    drain(1);

    for (int i = 0; i < 5; i++) send_word($urandom, 1'b1);
    in_valid = 1'b1;
    rst_n = 0;
    step(); in_valid = 1'b0; step();
    chk("pin_rst_busy", busy, 1'b0);
    chk("pin_rst_mid", midstate, 256'h0);
    rst_n = 1;
    step();
    for (int i = 0; i < 11; i++) job_w[i] = $urandom;
    load_job(1'b1);
    run_phase($urandom_range(1, TO), $urandom | 32'h1, $urandom);
    drain(3);

    for (int j = 0; j < 8; j++) begin
      for (int i = 0; i < 11; i++) job_w[i] = $urandom;
      load_job(1'($urandom_range(0, 1)));
      run_phase($urandom_range(0, TO), $urandom | 32'h1, $urandom);
      drain($urandom_range(0, 4));
    end

    step();
    chk("work_valid_pulses", 32'(wv_seen), 32'(n_jobs));
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
